// File: rtl/lfsr_req_scheduler_if.sv
// Request/response bundle between the random-number consumers and the
// shared LFSR scheduler. The consumer side is the master.
interface lfsr_req_scheduler_if #(
    parameter int NREQ  = 4,
    parameter int STEPW = 4
);
    logic                   seed_load;
    logic [3:0]             seed;
    logic [NREQ-1:0]        req;
    logic [NREQ*STEPW-1:0]  steps;
    logic [NREQ-1:0]        gnt;
    logic                   rsp_valid;
    logic [3:0]             rsp_data;
    logic                   rsp_ready;
    logic                   busy;
    logic [3:0]             lfsr_state;
    logic                   seed_err;

    modport master (
        output seed_load, seed, req, steps, rsp_ready,
        input  gnt, rsp_valid, rsp_data, busy, lfsr_state, seed_err
    );

    modport slave (
        input  seed_load, seed, req, steps, rsp_ready,
        output gnt, rsp_valid, rsp_data, busy, lfsr_state, seed_err
    );
endinterface

// File: rtl/lfsr_req_scheduler.sv
// Shares one 4-bit Fibonacci LFSR between NREQ requesters. Seeds are loaded
// while idle, requesters are granted round-robin, the LFSR is advanced by the
// winner's step count and the resulting state is returned over a
// valid/ready handshake.
module lfsr_req_scheduler #(
    parameter int         NREQ       = 4,
    parameter int         STEPW      = 4,
    parameter logic [3:0] RESET_SEED = 4'b0001
) (
    input  logic                  clk,
    input  logic                  rst,
    lfsr_req_scheduler_if.slave   bus
);
    localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state, state_nxt;
    logic [3:0]         lfsr, lfsr_nxt;
    logic [STEPW-1:0]   cnt, cnt_nxt;
    logic [PTRW-1:0]    ptr, ptr_nxt;
    logic [PTRW-1:0]    win, win_nxt;
    logic [NREQ-1:0]    gnt, gnt_nxt;
    logic               rsp_valid, rsp_valid_nxt;
    logic [3:0]         rsp_data, rsp_data_nxt;
    logic               seed_err, seed_err_nxt;

    logic               pick_found;
    logic [PTRW-1:0]    pick_idx;
    logic [STEPW-1:0]   pick_steps;
    logic [3:0]         lfsr_step;

    // One Fibonacci step: the new MSB is the XOR of the two low taps.
    function automatic logic [3:0] step_fn(input logic [3:0] s);
        return {s[1] ^ s[0], s[3], s[2], s[1]};
    endfunction

    // Requester index base+off, wrapped into 0..NREQ-1.
    function automatic logic [PTRW-1:0] wrap_idx(input logic [PTRW-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NREQ) sum = sum - NREQ;
        return PTRW'(sum);
    endfunction

    assign lfsr_step  = step_fn(lfsr);
    assign pick_steps = bus.steps[int'(pick_idx)*STEPW +: STEPW];

    // Round-robin search: first asserted req at or after the pointer.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int off = 0; off < NREQ; off++) begin
            if (!pick_found && bus.req[wrap_idx(ptr, off)]) begin
                pick_found = 1'b1;
                pick_idx   = wrap_idx(ptr, off);
            end
        end
    end

    // Next-state and next-output logic for the IDLE/RUN/DONE sequencer.
    always_comb begin
        // NOTE: every target gets a hold-value default first, so no path can leave one unassigned and infer a latch.
        state_nxt     = state;
        lfsr_nxt      = lfsr;
        cnt_nxt       = cnt;
        ptr_nxt       = ptr;
        win_nxt       = win;
        gnt_nxt       = gnt;
        rsp_valid_nxt = rsp_valid;
        rsp_data_nxt  = rsp_data;
        seed_err_nxt  = seed_err;

        unique case (state)
            IDLE: begin
                if (bus.seed_load) begin
                    // A zero seed would lock the LFSR; substitute 1 and flag it.
                    if (bus.seed == 4'd0) begin
                        lfsr_nxt     = 4'b0001;
                        seed_err_nxt = 1'b1;
                    end else begin
                        lfsr_nxt = bus.seed;
                    end
                end else if (pick_found) begin
                    gnt_nxt = NREQ'(1) << pick_idx;
                    win_nxt = pick_idx;
                    cnt_nxt = pick_steps;
                    if (pick_steps == '0) begin
                        state_nxt     = DONE;
                        rsp_valid_nxt = 1'b1;
                        rsp_data_nxt  = lfsr;
                    end else begin
                        state_nxt = RUN;
                    end
                end
            end

            RUN: begin
                lfsr_nxt = lfsr_step;
                cnt_nxt  = cnt - 1'b1;
                if (cnt == STEPW'(1)) begin
                    state_nxt     = DONE;
                    rsp_valid_nxt = 1'b1;
                    rsp_data_nxt  = lfsr_step;
                end
            end

            DONE: begin
                if (bus.rsp_ready) begin
                    state_nxt     = IDLE;
                    gnt_nxt       = '0;
                    rsp_valid_nxt = 1'b0;
                    ptr_nxt       = wrap_idx(win, 1);
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
        if (rst) begin
            state     <= IDLE;
            lfsr      <= RESET_SEED;
            cnt       <= '0;
            ptr       <= '0;
            win       <= '0;
            gnt       <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            seed_err  <= 1'b0;
        end else begin
            state     <= state_nxt;
            lfsr      <= lfsr_nxt;
            cnt       <= cnt_nxt;
            ptr       <= ptr_nxt;
            win       <= win_nxt;
            gnt       <= gnt_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_data  <= rsp_data_nxt;
            seed_err  <= seed_err_nxt;
        end
    end

    assign bus.gnt        = gnt;
    assign bus.rsp_valid  = rsp_valid;
    assign bus.rsp_data   = rsp_data;
    assign bus.busy       = (state != IDLE);
    assign bus.lfsr_state = lfsr;
    assign bus.seed_err   = seed_err;
endmodule

// File: tb/tb_lfsr_req_scheduler.sv
// Self-checking bench for lfsr_req_scheduler: directed scenarios followed by
// randomized transactions, compared against an orbit-table reference model.
module tb_lfsr_req_scheduler;
    localparam int NREQ  = 4;
    localparam int STEPW = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    lfsr_req_scheduler_if #(.NREQ(NREQ), .STEPW(STEPW)) bus ();

    lfsr_req_scheduler #(
        .NREQ       (NREQ),
        .STEPW      (STEPW),
        .RESET_SEED (4'b0001)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: the 15-state orbit starting at 0001, plus a position
    // in it, the round-robin pointer and the sticky seed error.
    logic [3:0]             orbit [15];
    int                     m_pos;
    int                     m_ptr;
    logic                   m_seed_err;
    logic [NREQ*STEPW-1:0]  steps_v;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pos_of(input logic [3:0] v);
        for (int i = 0; i < 15; i++) if (orbit[i] == v) return i;
        return 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_pos      = 0;
        m_ptr      = 0;
        m_seed_err = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_gnt"},   32'(bus.gnt),        32'h0);
        check({tag, "_valid"}, 32'(bus.rsp_valid),  32'h0);
        check({tag, "_data"},  32'(bus.rsp_data),   32'h0);
        check({tag, "_busy"},  32'(bus.busy),       32'h0);
        check({tag, "_lfsr"},  32'(bus.lfsr_state), 32'h1);
        check({tag, "_serr"},  32'(bus.seed_err),   32'h0);
    endtask

    task automatic load_seed(input logic [3:0] s);
        bus.seed_load = 1'b1;
        bus.seed      = s;
        tick();
        bus.seed_load = 1'b0;
        if (s == 4'd0) begin
            m_pos      = 0;
            m_seed_err = 1'b1;
        end else begin
            m_pos = pos_of(s);
        end
        check("seed_lfsr", 32'(bus.lfsr_state), 32'(orbit[m_pos]));
        check("seed_err",  32'(bus.seed_err),   32'(m_seed_err));
        check("seed_busy", 32'(bus.busy),       32'h0);
    endtask

    // One full transaction: pick, N steps, optional backpressure, handshake.
    task automatic run_txn(input logic [NREQ-1:0] reqv, input int delay, input bit hold_req,
                           input bit noise, output logic [NREQ-1:0] g_obs);
        int w;
        int n;
        int idx;
        w = -1;
        bus.req = reqv;
        tick();
        for (int off = 0; off < NREQ; off++) begin
            idx = (m_ptr + off) % NREQ;
            if (w < 0 && reqv[idx]) w = idx;
        end
        n = int'(steps_v[w*STEPW +: STEPW]);
        g_obs = bus.gnt;
        check("pick_gnt",  32'(bus.gnt),  32'(1) << w);
        check("pick_busy", 32'(bus.busy), 32'h1);
        if (!hold_req) bus.req = '0;
        for (int i = 1; i <= n; i++) begin
            if (noise) begin
                bus.seed_load = 1'($urandom_range(0, 1));
                bus.seed      = 4'($urandom);
                bus.rsp_ready = 1'($urandom_range(0, 1));
                if (!hold_req) bus.req = NREQ'($urandom);
            end
            tick();
            m_pos = (m_pos + 1) % 15;
            check("run_lfsr", 32'(bus.lfsr_state), 32'(orbit[m_pos]));
            check("run_gnt",  32'(bus.gnt),        32'(1) << w);
            if (i < n) check("run_valid", 32'(bus.rsp_valid), 32'h0);
        end
        bus.seed_load = 1'b0;
        bus.rsp_ready = 1'b0;
        if (!hold_req) bus.req = '0;
        check("done_valid", 32'(bus.rsp_valid),  32'h1);
        check("done_data",  32'(bus.rsp_data),   32'(orbit[m_pos]));
        check("done_busy",  32'(bus.busy),       32'h1);
        for (int d = 0; d < delay; d++) begin
            if (noise) begin
                bus.seed_load = 1'($urandom_range(0, 1));
                bus.seed      = 4'($urandom);
            end
            tick();
            check("hold_valid", 32'(bus.rsp_valid),  32'h1);
            check("hold_gnt",   32'(bus.gnt),        32'(1) << w);
            check("hold_lfsr",  32'(bus.lfsr_state), 32'(orbit[m_pos]));
            check("hold_data",  32'(bus.rsp_data),   32'(orbit[m_pos]));
        end
        bus.seed_load = 1'b0;
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        check("ack_valid", 32'(bus.rsp_valid),  32'h0);
        check("ack_gnt",   32'(bus.gnt),        32'h0);
        check("ack_busy",  32'(bus.busy),       32'h0);
        check("ack_data",  32'(bus.rsp_data),   32'(orbit[m_pos]));
        check("ack_lfsr",  32'(bus.lfsr_state), 32'(orbit[m_pos]));
        m_ptr = (w + 1) % NREQ;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NREQ-1:0] g;
        logic [NREQ-1:0] rr_exp [5];
        logic [NREQ-1:0] reqv;
        logic [3:0]      s;

        orbit[0] = 4'b0001;
        for (int i = 0; i < 14; i++)
            orbit[i+1] = {orbit[i][1] ^ orbit[i][0], orbit[i][3:1]};

        bus.seed_load = 1'b0;
        bus.seed      = '0;
        bus.req       = '0;
        bus.steps     = '0;
        bus.rsp_ready = 1'b0;
        steps_v       = '0;
        rst           = 1'b1;
        tick();
        do_reset();
        check_reset_outputs("reset");

        // Seed-and-sequence: 1111 stepped three times gives 0111, 0011, 0001.
        load_seed(4'b1111);
        steps_v[3:0] = 4'd3;
        bus.steps = steps_v;
        run_txn(4'b0001, 0, 1'b0, 1'b0, g);
        check("seq_gnt",  32'(g),            32'h1);
        check("seq_data", 32'(bus.rsp_data), 32'h1);

        // Back-to-back: requester 1, four steps from 0001 ends at 1001.
        steps_v[7:4] = 4'd4;
        bus.steps = steps_v;
        run_txn(4'b0010, 0, 1'b0, 1'b0, g);
        check("b2b_gnt",  32'(g),            32'h2);
        check("b2b_data", 32'(bus.rsp_data), 32'h9);

        // Full period returns to the seed.
        load_seed(4'b1111);
        steps_v[3:0] = 4'd15;
        bus.steps = steps_v;
        run_txn(4'b0001, 0, 1'b0, 1'b0, g);
        check("period_data", 32'(bus.rsp_data), 32'hF);

        // Round-robin fairness with all requesters asserted.
        do_reset();
        steps_v = {NREQ{4'd1}};
        bus.steps = steps_v;
        rr_exp[0] = 4'b0001;
        rr_exp[1] = 4'b0010;
        rr_exp[2] = 4'b0100;
        rr_exp[3] = 4'b1000;
        rr_exp[4] = 4'b0001;
        for (int k = 0; k < 5; k++) begin
            run_txn(4'b1111, 0, 1'b1, 1'b0, g);
            check("rr_order", 32'(g), 32'(rr_exp[k]));
        end
        bus.req = '0;

        // Zero seed in the same cycle as a request: load wins, grant waits.
        bus.seed_load = 1'b1;
        bus.seed      = 4'b0000;
        bus.req       = 4'b0001;
        tick();
        bus.seed_load = 1'b0;
        m_pos      = 0;
        m_seed_err = 1'b1;
        check("zseed_lfsr", 32'(bus.lfsr_state), 32'h1);
        check("zseed_err",  32'(bus.seed_err),   32'h1);
        check("zseed_gnt",  32'(bus.gnt),        32'h0);
        check("zseed_busy", 32'(bus.busy),       32'h0);
        run_txn(4'b0001, 0, 1'b0, 1'b0, g);
        check("zseed_late_gnt", 32'(g), 32'h1);

        // Zero steps with five cycles of backpressure.
        load_seed(4'b0110);
        steps_v[3:0] = 4'd0;
        bus.steps = steps_v;
        run_txn(4'b0001, 5, 1'b0, 1'b0, g);
        check("zstep_data", 32'(bus.rsp_data), 32'h6);

        // Reset in the second cycle of a ten-step run.
        steps_v[11:8] = 4'd10;
        bus.steps = steps_v;
        bus.req = 4'b0100;
        tick();
        check("rmid_gnt", 32'(bus.gnt), 32'h4);
        bus.req = '0;
        tick();
        check("rmid_busy", 32'(bus.busy), 32'h1);
        do_reset();
        check_reset_outputs("rmid");
        steps_v = {NREQ{4'd1}};
        bus.steps = steps_v;
        run_txn(4'b1111, 0, 1'b0, 1'b0, g);
        check("rmid_ptr", 32'(g), 32'h1);

        // Randomized transactions with ignored-input noise during RUN/DONE.
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 3) == 0) begin
                s = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
                load_seed(s);
            end
            steps_v   = (NREQ*STEPW)'($urandom);
            bus.steps = steps_v;
            reqv      = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            run_txn(reqv, int'($urandom_range(0, 3)), 1'b0, 1'b1, g);
        end
        check("final_serr", 32'(bus.seed_err), 32'(m_seed_err));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
